// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder: decodes READ + address and streams word-wide memory data MSB-first on MISO.
// Optional FAST READ (0x0B + 8 dummy clocks) is enabled by defining SPI_FLASH_FASTREAD_EN.
`timescale 1ns/1ps
module spi_flash_resp #(
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter int         ADDR_BITS   = 24,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_sck,
  input  logic                 spi_ss_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 mem_ren,
  output logic [ADDR_BITS-3:0] mem_raddr,
  input  logic [31:0]          mem_rdata,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int         WADDR_W  = ADDR_BITS - 2;
  localparam int         CNT_W    = $clog2(ADDR_BITS + 1);
  localparam logic [7:0] CMD_FAST = 8'h0B;

`ifdef SPI_FLASH_FASTREAD_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_FETCH, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  state_t state_q, state_d;

  // Input synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_q, ss_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_fall, ss_rise;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // SCK edges only count while the chip is selected.
  assign sck_rise = sck_s & ~sck_q & ~ss_s;
  assign sck_fall = ~sck_s & sck_q & ~ss_s;
  assign ss_fall  = ss_q & ~ss_s;
  assign ss_rise  = ~ss_q & ss_s;
  assign busy     = ~ss_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_q     <= sck_s;
      ss_q      <= ss_s;
    end
  end

  // Serial datapath state
  logic [ADDR_BITS-2:0] shift_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 fast_q;
  logic                 ren_q;
  logic [31:0]          cur_word, next_word;
  logic [1:0]           lane;
  logic [2:0]           bit_idx;
  logic                 word_done;
  logic                 need_pf;

  logic [7:0]           cmd_byte;
  logic [ADDR_BITS-1:0] addr_full;
  logic                 cmd_last, addr_last, dummy_last;
  logic                 cmd_ok, cmd_is_fast;
  logic                 err_d;

  assign cmd_byte    = {shift_q[6:0], mosi_s};
  assign addr_full   = {shift_q, mosi_s};
  assign cmd_last    = sck_rise && (bit_cnt == CNT_W'(7));
  assign addr_last   = sck_rise && (bit_cnt == CNT_W'(ADDR_BITS - 1));
  assign dummy_last  = sck_rise && (bit_cnt == CNT_W'(7));
  assign cmd_is_fast = FAST_EN && (cmd_byte == CMD_FAST);
  assign cmd_ok      = (cmd_byte == CMD_READ) || cmd_is_fast;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (ss_rise) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (ss_fall) state_d = S_CMD;
        S_CMD: begin
          if (cmd_last) begin
            if (cmd_ok) begin
              state_d = S_ADDR;
            end else begin
              state_d = S_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
        S_ADDR:   if (addr_last) state_d = S_FETCH;
        S_FETCH:  if (ren_q) state_d = fast_q ? S_DUMMY : S_DATA;
        S_DUMMY:  if (dummy_last) state_d = S_DATA;
        S_DATA:   state_d = S_DATA;
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_err   <= 1'b0;
      spi_miso  <= 1'b1;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      ren_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      fast_q    <= 1'b0;
      cur_word  <= '0;
      next_word <= '0;
      lane      <= '0;
      bit_idx   <= '0;
      word_done <= 1'b0;
      need_pf   <= 1'b0;
    end else begin
      cmd_err <= err_d;
      mem_ren <= 1'b0;
      ren_q   <= mem_ren;

      if (ss_rise) begin
        // Transaction aborted: drop partial command and any fetch in flight.
        spi_miso  <= 1'b1;
        shift_q   <= '0;
        bit_cnt   <= '0;
        fast_q    <= 1'b0;
        lane      <= '0;
        bit_idx   <= '0;
        word_done <= 1'b0;
        need_pf   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            spi_miso <= 1'b1;
            if (ss_fall) begin
              shift_q <= '0;
              bit_cnt <= '0;
            end
          end

          S_CMD: begin
            if (sck_rise) begin
              shift_q <= {shift_q[ADDR_BITS-3:0], mosi_s};
              if (cmd_last) begin
                bit_cnt <= '0;
                fast_q  <= cmd_is_fast;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          S_ADDR: begin
            if (sck_rise) begin
              shift_q <= {shift_q[ADDR_BITS-3:0], mosi_s};
              if (addr_last) begin
                bit_cnt   <= '0;
                mem_ren   <= 1'b1;
                mem_raddr <= addr_full[ADDR_BITS-1:2];
                lane      <= addr_full[1:0];
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          S_FETCH: begin
            if (ren_q) begin
              cur_word  <= mem_rdata;
              bit_idx   <= 3'd7;
              word_done <= 1'b0;
              need_pf   <= 1'b1;
            end
          end

          S_DUMMY, S_DATA: begin
            // One prefetch outstanding at most, never on back-to-back cycles.
            if (need_pf && !mem_ren && !ren_q) begin
              mem_ren   <= 1'b1;
              mem_raddr <= mem_raddr + WADDR_W'(1);
              need_pf   <= 1'b0;
            end
            if (ren_q) next_word <= mem_rdata;

            if (state_q == S_DUMMY) begin
              if (sck_rise) bit_cnt <= dummy_last ? '0 : bit_cnt + CNT_W'(1);
            end else if (sck_fall) begin
              if (word_done) begin
                cur_word  <= next_word;
                spi_miso  <= next_word[7];
                lane      <= 2'd0;
                bit_idx   <= 3'd6;
                word_done <= 1'b0;
                need_pf   <= 1'b1;
              end else begin
                spi_miso <= cur_word[{lane, bit_idx}];
                if (bit_idx == 3'd0) begin
                  bit_idx <= 3'd7;
                  if (lane == 2'd3) word_done <= 1'b1;
                  else              lane      <= lane + 2'd1;
                end else begin
                  bit_idx <= bit_idx - 3'd1;
                end
              end
            end
          end

          S_IGNORE: spi_miso <= 1'b1;

          default: spi_miso <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Self-checking bench for spi_flash_resp: directed cases plus random reads against a byte-stream model.
`timescale 1ns/1ps
module tb_spi_flash_resp;

  localparam int ADDR_BITS   = 24;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        mem_ren;
  logic [21:0] mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        cmd_err;

  spi_flash_resp #(
    .CMD_READ(8'h03), .ADDR_BITS(ADDR_BITS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock(clock), .reset(reset),
    .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash contents: two fixed words, everything else a hash of the word address.
  function automatic logic [31:0] mem_word(input logic [21:0] a);
    if (a == 22'd1) return 32'h44332211;
    if (a == 22'd2) return 32'h88776655;
    return ({10'd0, a} * 32'h9E3779B1) ^ 32'hA5C30F17;
  endfunction

  // Reference: byte at flash byte address a, little-endian lanes within each word.
  function automatic logic [7:0] exp_byte(input logic [23:0] a);
    logic [31:0] w;
    w = mem_word(a[23:2]);
    return 8'(w >> (8 * int'(a[1:0])));
  endfunction

  // Synchronous read port: data one clock after the strobe.
  always @(posedge clock) begin
    if (mem_ren) mem_rdata <= mem_word(mem_raddr);
  end

  int          ren_count = 0;
  int          err_count = 0;
  int          ren_b2b   = 0;
  logic        ren_prev  = 1'b0;
  logic [21:0] raddr_log[$];

  always @(negedge clock) begin
    if (mem_ren) begin
      ren_count++;
      raddr_log.push_back(mem_raddr);
    end
    if (mem_ren && ren_prev) ren_b2b++;
    ren_prev = mem_ren;
    if (cmd_err) err_count++;
  end

  task automatic spi_bit(input logic mosi_v, output logic miso_v);
    spi_mosi = mosi_v;
    repeat (HALF) @(negedge clock);
    miso_v  = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic ss_begin();
    @(negedge clock);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic ss_end();
    repeat (HALF) @(negedge clock);
    spi_ss_n = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic read_and_check(input string tag, input logic [7:0] op, input logic [23:0] a,
                                input int nbytes, input bit dummy);
    logic [7:0]  rx;
    logic [23:0] ba;
    int          idle_bad;
    int          err0;
    idle_bad = 0;
    err0     = err_count;
    ss_begin();
    check({tag, " busy"}, busy, 1'b1);
    xfer_byte(op, rx);           if (rx != 8'hFF) idle_bad++;
    xfer_byte(a[23:16], rx);     if (rx != 8'hFF) idle_bad++;
    xfer_byte(a[15:8], rx);      if (rx != 8'hFF) idle_bad++;
    xfer_byte(a[7:0], rx);       if (rx != 8'hFF) idle_bad++;
    if (dummy) begin
      xfer_byte(8'($urandom), rx); if (rx != 8'hFF) idle_bad++;
    end
    check({tag, " miso idle"}, idle_bad, 0);
    for (int k = 0; k < nbytes; k++) begin
      ba = a + 24'(k);
      xfer_byte(8'($urandom), rx);
      check($sformatf("%s byte%0d", tag, k), rx, exp_byte(ba));
    end
    ss_end();
    check({tag, " no cmd_err"}, err_count - err0, 0);
  endtask

  task automatic bad_opcode(input string tag, input logic [7:0] op);
    logic [7:0] rx;
    int err0, ren0, bad;
    err0 = err_count;
    ren0 = ren_count;
    bad  = 0;
    ss_begin();
    xfer_byte(op, rx);
    for (int k = 0; k < 4; k++) begin
      xfer_byte(8'($urandom), rx);
      if (rx != 8'hFF) bad++;
    end
    ss_end();
    check({tag, " cmd_err pulses"}, err_count - err0, 1);
    check({tag, " no mem_ren"}, ren_count - ren0, 0);
    check({tag, " miso high"}, bad, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx;
    logic        m;
    logic [23:0] ra;
    int          err0;

    // Reset state
    repeat (5) @(negedge clock);
    check("rst miso", spi_miso, 1'b1);
    check("rst mem_ren", mem_ren, 1'b0);
    check("rst raddr", mem_raddr, 22'd0);
    check("rst busy", busy, 1'b0);
    check("rst cmd_err", cmd_err, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Single word, aligned
    raddr_log.delete();
    read_and_check("rd4", 8'h03, 24'h000004, 4, 1'b0);
    check("rd4 raddr0", (raddr_log.size() > 0) ? raddr_log[0] : 22'h3FFFFF, 22'd1);

    // Unaligned start crossing words
    raddr_log.delete();
    read_and_check("rd6", 8'h03, 24'h000006, 8, 1'b0);
    check("rd6 nfetch", raddr_log.size() >= 3, 1'b1);
    if (raddr_log.size() >= 3) begin
      check("rd6 raddr0", raddr_log[0], 22'd1);
      check("rd6 raddr1", raddr_log[1], 22'd2);
      check("rd6 raddr2", raddr_log[2], 22'd3);
    end

    // Word address wrap at top of flash
    raddr_log.delete();
    read_and_check("wrap", 8'h03, 24'hFFFFFC, 8, 1'b0);
    check("wrap nfetch", raddr_log.size() >= 2, 1'b1);
    if (raddr_log.size() >= 2) begin
      check("wrap raddr0", raddr_log[0], 22'h3FFFFF);
      check("wrap raddr1", raddr_log[1], 22'h000000);
    end

    // Unsupported opcode
    bad_opcode("op9F", 8'h9F);

    // Partial address then aborted, followed by a clean read
    err0 = err_count;
    ss_begin();
    xfer_byte(8'h03, rx);
    for (int i = 0; i < 12; i++) spi_bit(1'($urandom), m);
    ss_end();
    check("abort no cmd_err", err_count - err0, 0);
    read_and_check("rd0", 8'h03, 24'h000000, 4, 1'b0);

`ifdef SPI_FLASH_FASTREAD_EN
    read_and_check("fast0", 8'h0B, 24'h000000, 4, 1'b1);
    read_and_check("fast5", 8'h0B, 24'h000005, 6, 1'b1);
`else
    bad_opcode("op0B", 8'h0B);
`endif

    // Async reset in the middle of data output
    ss_begin();
    xfer_byte(8'h03, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h10, rx);
    xfer_byte(8'h00, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst miso", spi_miso, 1'b1);
    check("midrst mem_ren", mem_ren, 1'b0);
    check("midrst busy", busy, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (SYNC_STAGES + 1) @(posedge clock);
    @(negedge clock);
    check("postrst busy low ss", busy, 1'b1);
    spi_ss_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clock);
    check("postrst busy high ss", busy, 1'b0);
    check("postrst miso", spi_miso, 1'b1);
    read_and_check("postrst rd", 8'h03, 24'h000010, 2, 1'b0);

    // Random reads against the model
    for (int t = 0; t < 6; t++) begin
      ra = 24'($urandom);
`ifdef SPI_FLASH_FASTREAD_EN
      if ($urandom_range(1, 0) == 1)
        read_and_check($sformatf("rndf%0d", t), 8'h0B, ra, int'($urandom_range(12, 1)), 1'b1);
      else
`endif
      read_and_check($sformatf("rnd%0d", t), 8'h03, ra, int'($urandom_range(12, 1)), 1'b0);
    end

    check("mem_ren never back-to-back", ren_b2b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
